// File: rtl/freqmeter_top.sv
// freqmeter_top: 24-channel gated frequency counter with a UART query port.
// Each channel counts synchronized rising edges of its Fin bit over a window
// of GATE_CYCLES clocks. At the end of each window the count is latched into
// that channel's result register. A received byte 0x00..0x17 makes the block
// reply with that channel's result: 3 bytes, MSB first.
// SPI and Ethernet pins are tied to their idle levels.
// Optional build macro: TX1_MIRROR_EN (tx1 mirrors tx0; otherwise tx1 = 1).
module freqmeter_top #(
    parameter int GATE_CYCLES  = 1000,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx0,
    output logic        tx0,
    output logic        tx1,
    output logic        flash_CS,
    output logic        sck_o,
    output logic        mosi_o,
    input  logic        miso_i,
    input  logic [1:0]  phy_rmii_rxdata,
    input  logic        phy_rmii_crs_rxdv,
    output logic [1:0]  phy_rmii_txdata,
    output logic        phy_rmii_txen,
    output logic        phy_rmii_clk,
    output logic        phy_mii_clk_o,
    inout  wire         phy_mii_data_io,
    input  logic [23:0] Fin
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Idle peripherals
    assign flash_CS        = 1'b1;
    assign sck_o           = 1'b0;
    assign mosi_o          = 1'b0;
    assign phy_rmii_txdata = 2'b00;
    assign phy_rmii_txen   = 1'b0;
    assign phy_rmii_clk    = clk_i;
    assign phy_mii_clk_o   = 1'b0;
    assign phy_mii_data_io = 1'bz;

    logic unused_inputs;
    assign unused_inputs = ^{miso_i, phy_rmii_rxdata, phy_rmii_crs_rxdv};

    // ---------------- frequency counting ----------------
    logic [23:0]   fin_s1, fin_s2, fin_prev, rise;
    logic [GW-1:0] gate_cnt;
    logic          gate_end;
    logic [23:0]   edge_cnt [24];
    logic [23:0]   cnt_inc  [24];
    logic [23:0]   result   [24];

    assign rise     = fin_s2 & ~fin_prev;
    assign gate_end = (gate_cnt == GATE_LAST);

    // Two-flop synchronizer plus previous-value flop for edge detection
    always_ff @(posedge clk_i) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            fin_s1   <= '0;
            fin_s2   <= '0;
            fin_prev <= '0;
        end else begin
            fin_s1   <= Fin;
            fin_s2   <= fin_s1;
            fin_prev <= fin_s2;
        end
    end

    // Free-running measurement window counter
    always_ff @(posedge clk_i) begin
        if (rst_i)         gate_cnt <= '0;
        else if (gate_end) gate_cnt <= '0;
        else               gate_cnt <= gate_cnt + GW'(1);
    end

    // Saturating increment of each channel count
    always_comb begin
        for (int i = 0; i < 24; i++) begin
            // NOTE: assign a default before any condition so no latch is inferred.
            cnt_inc[i] = edge_cnt[i];
            if (rise[i] && (edge_cnt[i] != 24'hFFFFFF))
                cnt_inc[i] = edge_cnt[i] + 24'd1;
        end
    end

    // Accumulate edges; at gate end latch the count (incl. this cycle's edge) and restart
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: these arrays are flops, not RAM, so clearing them on reset is legitimate.
            for (int i = 0; i < 24; i++) begin
                edge_cnt[i] <= '0;
                result[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 24; i++) begin
                if (gate_end) begin
                    result[i]   <= cnt_inc[i];
                    edge_cnt[i] <= '0;
                end else begin
                    edge_cnt[i] <= cnt_inc[i];
                end
            end
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t     rx_state_q, rx_state_d;
    logic          rx_s1, rx_s2;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_data;
    logic          rx_cnt_clr, rx_shift_en, rx_valid;

    // Receiver state register and line synchronizer (reset to idle-high)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q <= RX_IDLE;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_s1      <= rx0;
            rx_s2      <= rx_s1;
        end
    end

    // Receiver next-state: mid-bit sampling, stop-bit validation, wait out breaks
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_clr  = 1'b0;
        rx_shift_en = 1'b0;
        rx_valid    = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (!rx_s2) begin
                rx_state_d = RX_START;
                rx_cnt_clr = 1'b1;
            end
            RX_START: if (rx_cnt == HALF_BIT) begin
                rx_cnt_clr = 1'b1;
                rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == FULL_BIT) begin
                rx_cnt_clr  = 1'b1;
                rx_shift_en = 1'b1;
                if (rx_bit == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt == FULL_BIT) begin
                rx_cnt_clr = 1'b1;
                if (rx_s2) begin
                    rx_valid   = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: if (rx_s2) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver bit timer and shift register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_data <= '0;
        end else begin
            rx_cnt <= rx_cnt_clr ? '0 : rx_cnt + CW'(1);
            if (rx_state_q == RX_IDLE) rx_bit <= '0;
            else if (rx_shift_en)      rx_bit <= rx_bit + 3'd1;
            if (rx_shift_en) rx_data <= {rx_s2, rx_data[7:1]};
        end
    end

    // ---------------- reply transmitter ----------------
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [1:0]    tx_byte;
    logic [23:0]   tx_shift;
    logic [7:0]    tx_cur;
    logic          tx_q, tx_line, tx_cnt_clr, tx_bit_adv, tx_byte_adv, cmd_go;

    assign cmd_go = rx_valid && (rx_data < 8'd24) && (tx_state_q == TX_IDLE);
    assign tx_cur = tx_shift[23:16];
    assign tx0    = tx_q;

    // Transmitter state register and registered line output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_q       <= tx_line;
        end
    end

    // Transmitter next-state: 3 back-to-back 8N1 frames, no gap between them
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_line     = 1'b1;
        tx_cnt_clr  = 1'b0;
        tx_bit_adv  = 1'b0;
        tx_byte_adv = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (cmd_go) begin
                tx_state_d = TX_START;
                tx_cnt_clr = 1'b1;
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_cnt == FULL_BIT) begin
                    tx_cnt_clr = 1'b1;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_line = tx_cur[tx_bit];
                if (tx_cnt == FULL_BIT) begin
                    tx_cnt_clr = 1'b1;
                    tx_bit_adv = 1'b1;
                    if (tx_bit == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: if (tx_cnt == FULL_BIT) begin
                tx_cnt_clr  = 1'b1;
                tx_byte_adv = 1'b1;
                tx_state_d  = (tx_byte == 2'd2) ? TX_IDLE : TX_START;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Transmitter timer, bit/byte indices and reply snapshot
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_shift <= '0;
        end else begin
            tx_cnt <= tx_cnt_clr ? '0 : tx_cnt + CW'(1);
            if (cmd_go) begin
                tx_shift <= result[rx_data[4:0]];
                tx_bit   <= '0;
                tx_byte  <= '0;
            end else begin
                if (tx_bit_adv) tx_bit <= tx_bit + 3'd1;
                if (tx_byte_adv) begin
                    tx_byte  <= tx_byte + 2'd1;
                    tx_shift <= {tx_shift[15:0], 8'h00};
                end
            end
        end
    end

`ifdef TX1_MIRROR_EN
    assign tx1 = tx0;
`else
    assign tx1 = 1'b1;
`endif

endmodule

// File: tb/tb_freqmeter_top.sv
// Scoreboard bench for freqmeter_top: randomized Fin square waves and UART
// commands. A window-level model predicts each reply; a UART monitor
// decodes tx0 and checks it against the queued expectations.
module tb_freqmeter_top;

    localparam int G   = 1000;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx0 = 1'b1;
    logic        miso_i = 1'b0;
    logic [1:0]  rmii_rxd = 2'b00;
    logic        rmii_dv = 1'b0;
    logic [23:0] fin_gen = '0;
    logic        fin3 = 1'b0;
    wire  [23:0] fin = {fin_gen[23:4], fin3, fin_gen[2:0]};
    wire         mdio;
    logic        tx0, tx1, flash_cs, sck, mosi, rmii_txen, rmii_clk, mii_clk;
    logic [1:0]  rmii_txd;

    freqmeter_top #(.GATE_CYCLES(G), .CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk), .rst_i(rst_i), .rx0(rx0), .tx0(tx0), .tx1(tx1),
        .flash_CS(flash_cs), .sck_o(sck), .mosi_o(mosi), .miso_i(miso_i),
        .phy_rmii_rxdata(rmii_rxd), .phy_rmii_crs_rxdv(rmii_dv),
        .phy_rmii_txdata(rmii_txd), .phy_rmii_txen(rmii_txen),
        .phy_rmii_clk(rmii_clk), .phy_mii_clk_o(mii_clk),
        .phy_mii_data_io(mdio), .Fin(fin)
    );

    always #5 clk = ~clk;

    typedef struct { int lo; int hi; int ch; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int half_per [24];
    int phase    [24];
    int nbytes = 0;
    int mon_bytes = 0;
    int tx_low = 0;
    bit mon_en = 1'b1;
    logic [23:0] acc = '0;
    logic [7:0]  mon_b;
    exp_t        mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] got, input int lo, input int hi);
        checks++;
        if ($isunknown(got) || got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Clock index since the last reset edge: cycle k is window k/G, position k%G
    always @(posedge clk) begin
        if (rst_i) cyc = 0;
        else       cyc = cyc + 1;
    end

    // Square-wave generators (half_per==0 means constant level)
    always @(negedge clk) begin
        for (int i = 0; i < 24; i++) begin
            if (half_per[i] != 0) begin
                phase[i] = phase[i] + 1;
                if (phase[i] >= half_per[i]) begin
                    phase[i]   = 0;
                    fin_gen[i] = ~fin_gen[i];
                end
            end
        end
    end

    // Low-level activity counter for "no traffic" checks
    always @(negedge clk) begin
        if (!rst_i && tx0 === 1'b0) tx_low = tx_low + 1;
    end

    // UART monitor: decode tx0 bytes, assemble 3-byte replies, compare with scoreboard
    always begin
        @(negedge tx0);
        if (mon_en && !rst_i) begin
            repeat (CPB / 2) @(negedge clk);
            check("start bit", tx0, 1'b0);
`ifdef TX1_MIRROR_EN
            check("tx1 mirror", tx1, tx0);
`else
            check("tx1 idle", tx1, 1'b1);
`endif
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_b[i] = tx0;
            end
            repeat (CPB) @(negedge clk);
            check("stop bit", tx0, 1'b1);
            acc = {acc[15:0], mon_b};
            nbytes = nbytes + 1;
            mon_bytes = mon_bytes + 1;
            if (nbytes == 3) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected reply: got %06h with nothing pending", acc);
                end else begin
                    mon_e = sb.pop_front();
                    check_range($sformatf("reply ch%0d", mon_e.ch), {8'h00, acc}, mon_e.lo, mon_e.hi);
                end
                nbytes = 0;
            end
        end
    end

    // Model: a P-cycle square wave has floor or ceil of G/P rising edges per window
    task automatic push_expected(input int ch);
        exp_t e;
        int p;
        e.ch = ch;
        if (half_per[ch] == 0) begin
            e.lo = 0;
            e.hi = 0;
        end else begin
            p    = 2 * half_per[ch];
            e.lo = G / p;
            e.hi = (G + p - 1) / p;
        end
        sb.push_back(e);
    endtask

    task automatic push_value(input int ch, input int v);
        exp_t e;
        e.ch = ch;
        e.lo = v;
        e.hi = v;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx0 = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx0 = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx0 = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || nbytes != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({"reply arrived ", name}, (n < 2000), 1'b1);
        if (n >= 2000) sb.delete();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, k, l0, b0, ch;
        for (int i = 0; i < 24; i++) begin
            phase[i] = 0;
            if (i == 0)       half_per[i] = 4;
            else if (i == 23) half_per[i] = 10;
            else if (i == 3)  half_per[i] = 0;
            else if ($urandom_range(0, 3) == 0) half_per[i] = 0;
            else half_per[i] = $urandom_range(2, 50);
            fin_gen[i] = (half_per[i] == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end

        // Reset state
        repeat (10) @(negedge clk);
        check("reset tx0", tx0, 1'b1);
        check("reset tx1", tx1, 1'b1);
        check("flash_CS", flash_cs, 1'b1);
        check("sck_o", sck, 1'b0);
        check("mosi_o", mosi, 1'b0);
        check("rmii_txen", rmii_txen, 1'b0);
        check("rmii_txdata", rmii_txd, 2'b00);
        check("mii_clk", mii_clk, 1'b0);
        check("mdio high-z", (mdio === 1'bz), 1'b1);
        check("rmii_clk low", rmii_clk, 1'b0);
        @(posedge clk);
        #1;
        check("rmii_clk high", rmii_clk, 1'b1);
        @(negedge clk);
        rst_i = 1'b0;

        // Channel 0 (period 8) exact 125 -> bytes 00 00 7D; channel 23 (period 20)
        wait_cyc(2050);
        push_value(0, 125);
        send_byte(8'h00);
        wait_drain("ch0");
        push_expected(23);
        send_byte(8'h17);
        wait_drain("ch23");

        // Long break: no reply, then a normal command
        l0 = tx_low;
        rx0 = 1'b0;
        repeat (500 * CPB) @(negedge clk);
        check("quiet during break", tx_low - l0, 0);
        rx0 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        push_expected(23);
        send_byte(8'h17);
        wait_drain("ch23 after break");

        // Out-of-range byte ignored; command during a reply dropped
        l0 = tx_low;
        send_byte(8'h18);
        repeat (40 * CPB) @(negedge clk);
        check("0x18 ignored", tx_low - l0, 0);
        b0 = mon_bytes;
        push_value(0, 125);
        send_byte(8'h00);
        send_byte(8'h05);
        wait_drain("ch0 busy");
        repeat (40 * CPB) @(negedge clk);
        check("busy command dropped", mon_bytes - b0, 3);

        // Random channel queries against the model
        for (int r = 0; r < 8; r++) begin
            ch = $urandom_range(0, 23);
            push_expected(ch);
            send_byte(8'(ch));
            wait_drain("random");
        end

        // Single Fin[3] edge detected on a gate-end cycle
        m = cyc / G + 2;
        k = m * G + G - 1;
        wait_cyc(k - 2);
        fin3 = 1'b1;
        wait_cyc(k + 1 + 60);
        push_value(3, 1);
        send_byte(8'h03);
        wait_drain("ch3 edge window");
        wait_cyc(k + 1 + G + 60);
        push_value(3, 0);
        send_byte(8'h03);
        wait_drain("ch3 next window");

        // Reset in the middle of a reply
        mon_en = 1'b0;
        send_byte(8'h00);
        for (int n = 0; n < 100 && tx0 !== 1'b0; n++) @(negedge clk);
        check("reply started", tx0, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("tx0 high after reset", tx0, 1'b1);
        check("tx1 high after reset", tx1, 1'b1);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        l0 = tx_low;
        repeat (40 * CPB) @(negedge clk);
        check("reply aborted", tx_low - l0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
